// File: rtl/decomp_ctrl_if.sv
// Bus bundle between the decompression controller and its environment.
//   fetch side  : fetch_word / fetch_valid in, fetch_ready out
//   token table : tt_addr / tt_ofs out, tt_len / tt_data back (combinational read)
//   decoder side: instr / instr_valid out, instr_ready in
// The master modport is the controller's view; the slave modport is the
// view of whatever surrounds it (memory, token table, decoder).
interface decomp_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int TOKW  = 8,
  parameter int LENW  = 3
);
  logic [WIDTH-1:0] fetch_word;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [TOKW-1:0]  tt_addr;
  logic [LENW-1:0]  tt_ofs;
  logic [LENW-1:0]  tt_len;
  logic [WIDTH-1:0] tt_data;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    input  fetch_word, fetch_valid, tt_len, tt_data, instr_ready,
    output fetch_ready, tt_addr, tt_ofs, instr, instr_valid
  );

  modport slave (
    output fetch_word, fetch_valid, tt_len, tt_data, instr_ready,
    input  fetch_ready, tt_addr, tt_ofs, instr, instr_valid
  );
endinterface

// File: rtl/decomp_ctrl.sv
// Instruction decompression controller.
// Plain fetch words pass straight to the decoder register with one cycle of
// latency. A token word (top nibble 4'hF) is replaced by the instruction
// sequence stored in the token table: one LOOKUP cycle reads its length,
// then EXPAND emits offsets 0..len-1 as the decoder slot frees up.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous, active-low reset
//   flush     - synchronous abort; drops the current instruction and expansion
//   bus       - fetch / token table / decoder bundle (master modport)
//   busy      - controller is not in IDLE
//   tok_err   - one-cycle pulse when a token has zero length
//   tok_count - number of completed token expansions (wraps)
module decomp_ctrl #(
  parameter int WIDTH = 32,
  parameter int TOKW  = 8,
  parameter int LENW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  decomp_ctrl_if.master     bus,
  output logic              busy,
  output logic              tok_err,
  output logic [15:0]       tok_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TOKW-1:0]  idx_q, idx_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             tok_err_q, tok_err_d;
  logic [15:0]      tok_count_q, tok_count_d;

  logic slot_free;
  logic fetch_ready_c;
  logic accept;
  logic is_token;
  logic last_ofs;

  // The output register can take a new word if empty or being drained now.
  assign slot_free     = !instr_valid_q || bus.instr_ready;
  // reset is folded in so fetch_ready reads 0 while the block is held in reset.
  assign fetch_ready_c = (state_q == ST_IDLE) && slot_free && !flush && reset;
  assign accept        = bus.fetch_valid && fetch_ready_c;
  assign is_token      = (bus.fetch_word[WIDTH-1 -: 4] == 4'hF);
  assign last_ofs      = (cnt_q == len_q - LENW'(1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    tok_err_d     = 1'b0;
    tok_count_d   = tok_count_q;

    // Default drain; any load below overrides it.
    if (bus.instr_ready) begin
      instr_valid_d = 1'b0;
    end

    if (flush) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_token) begin
              idx_d   = bus.fetch_word[TOKW-1:0];
              cnt_d   = '0;
              state_d = ST_LOOKUP;
            end else begin
              instr_d       = bus.fetch_word;
              instr_valid_d = 1'b1;
            end
          end
        end
        ST_LOOKUP: begin
          len_d = bus.tt_len;
          if (bus.tt_len == '0) begin
            tok_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (slot_free) begin
            instr_d       = bus.tt_data;
            instr_valid_d = 1'b1;
            cnt_d         = cnt_q + LENW'(1);
            if (last_ofs) begin
              state_d     = ST_IDLE;
              tok_count_d = tok_count_q + 16'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      tok_err_q     <= 1'b0;
      tok_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      tok_err_q     <= tok_err_d;
      tok_count_q   <= tok_count_d;
    end
  end

  assign bus.fetch_ready = fetch_ready_c;
  assign bus.tt_addr     = (state_q != ST_IDLE) ? idx_q : '0;
  assign bus.tt_ofs      = (state_q != ST_IDLE) ? cnt_q : '0;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign tok_err         = tok_err_q;
  assign tok_count       = tok_count_q;

endmodule

// File: doc/decomp_ctrl.md
DECOMP_CTRL -- requirements
Module: decomp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the instruction and fetch word width.
REQ-002 SHALL have parameter TOKW, default 8, meaning the token index width.
REQ-003 SHALL have parameter LENW, default 3, meaning the expansion length width (maximum 2^LENW-1 instructions per token).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port flush, input, 1 bit: synchronous abort from the hazard unit.
REQ-007 SHALL have port fetch_word, input, WIDTH bits: word from instruction memory.
REQ-008 SHALL have port fetch_valid, input, 1 bit: fetch_word valid.
REQ-009 SHALL have port fetch_ready, output, 1 bit: controller accepts fetch_word this cycle.
REQ-010 SHALL have port tt_addr, output, TOKW bits: token table index (combinational-read table).
REQ-011 SHALL have port tt_ofs, output, LENW bits: instruction offset within the token.
REQ-012 SHALL have port tt_len, input, LENW bits: expansion length of entry tt_addr.
REQ-013 SHALL have port tt_data, input, WIDTH bits: instruction at (tt_addr, tt_ofs).
REQ-014 SHALL have port instr, output, WIDTH bits: instruction to decoder (registered).
REQ-015 SHALL have port instr_valid, output, 1 bit: instr holds a valid instruction.
REQ-016 SHALL have port instr_ready, input, 1 bit: decoder consumes instr this cycle.
REQ-017 SHALL have port busy, output, 1 bit: state != IDLE.
REQ-018 SHALL have port tok_err, output, 1 bit: one-cycle pulse on zero-length token.
REQ-019 SHALL have port tok_count, output, 16 bits: count of completed token expansions; wraps 0xFFFF->0.

Function
REQ-020 SHALL define a token word as fetch_word[WIDTH-1:WIDTH-4]==4'b1111, with index fetch_word[TOKW-1:0]; every other word is plain.
REQ-021 SHALL define slot_free = !instr_valid || instr_ready.
REQ-022 SHALL drive fetch_ready = (state==IDLE) && slot_free && !flush && reset, combinationally.
REQ-023 SHALL, in IDLE on a plain word accept, load instr<=fetch_word and set instr_valid<=1 next edge, remaining in IDLE (1-cycle latency, full throughput).
REQ-024 SHALL, in IDLE on a token word accept, latch the index into idx, set cnt<=0, clear instr_valid if it is consumed, and go to LOOKUP.
REQ-025 SHALL drive tt_addr=idx and tt_ofs=cnt at all times outside IDLE, and 0 in IDLE.
REQ-026 SHALL, in LOOKUP, latch len<=tt_len; if tt_len==0, pulse tok_err and return to IDLE; otherwise go to EXPAND.
REQ-027 SHALL, in EXPAND when slot_free, load instr<=tt_data, set instr_valid<=1, and set cnt<=cnt+1.
REQ-028 SHALL, when the EXPAND load has cnt==len-1, return to IDLE and increment tok_count on that edge.
REQ-029 SHALL, in EXPAND when !slot_free, hold instr, instr_valid, cnt and state.
REQ-030 SHALL clear instr_valid whenever instr_ready=1 and no new load occurs that cycle.
REQ-031 SHALL, on flush=1, on the next edge set instr_valid<=0, state<=IDLE and cnt<=0, with no fetch accepted that cycle; flush has priority over every other transition, and tok_count is unchanged.
REQ-032 SHALL never emit a token word on instr; a token emits exactly len instructions, in offset order 0..len-1.

Reset
REQ-033 SHALL, while reset=0, asynchronously force state=IDLE, idx=0, cnt=0, len=0, instr=0, instr_valid=0, tok_err=0, tok_count=0 and fetch_ready=0.
REQ-034 SHALL, on reset deassertion mid-expansion, not resume; the first action is a new fetch accept from IDLE.

Verification
REQ-035 SHALL test plain stream: words 0xE0811002 and 0xE2433001 on consecutive cycles with instr_ready=1 -> each appears on instr one cycle later, fetch_ready held 1.
REQ-036 SHALL test token: fetch 0xF0000005 with table entry 5 of len=3 (A,B,C) -> LOOKUP for 1 cycle, then A, B, C on consecutive cycles, fetch_ready=0 during the sequence, tok_count 0->1, busy high for 4 cycles.
REQ-037 SHALL test backpressure: instr_ready=0 for 3 cycles during EXPAND at cnt=1 -> B held stable with instr_valid=1, and no skipped or duplicated offset.
REQ-038 SHALL test zero length: fetch token index 7 with tt_len=0 -> tok_err pulses exactly 1 cycle, no instr_valid, return to IDLE, tok_count unchanged.
REQ-039 SHALL test flush at cnt=1 of a len=4 token -> next cycle instr_valid=0, busy=0, fetch_ready=1, tok_count unchanged.
REQ-040 SHALL test reset mid-EXPAND: reset=0 asynchronously between edges -> all outputs at reset values immediately; after release, a plain word passes through normally.
